avion_io_responder: RTL and testbench

Memory-mapped I/O responder on the avion_cpu memory bus. It sits alongside blram on the same address, write-enable and write-data lines and claims a 4-word window at the top of the address space. Behind that window it holds a transmit FIFO that drains to an external consumer through a valid/ready handshake, a status register, a free-running cycle counter and a scratch register. Read data is registered with the same one-cycle latency as blram, and the top level muxes the two sources using `o_sel`.

---
 rtl/avion_io_responder.sv | 197 +++++++++++++++++++
 tb/tb_avion_io_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/avion_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : avion_io_responder
// Purpose  : Memory-mapped I/O responder on the avion_cpu memory bus. Claims
//            a 4-word window (BASE_ADDR..BASE_ADDR+3). The window holds:
//              +0 TXDATA  : push into the transmit FIFO / read the FIFO head
//              +1 STATUS  : {count[2:0], overflow, full, empty}; writing
//                           bit2 = 1 clears overflow
//              +2 CYCLE   : free-running cycle counter, loadable
//              +3 SCRATCH : plain read/write register
//            Read data is registered (one-cycle latency, like blram) and
//            o_sel tells the top level which source to mux in.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_we, i_addr,
//            i_data_in         - shared bus write enable / address / data
//            o_data_out, o_sel - registered read data and window-hit flag
//            o_tx_data,
//            o_tx_valid,
//            i_tx_ready        - FIFO drain handshake to the consumer
//            o_overflow        - sticky flag: push attempted while full
// Revision : 1.0 - initial release
// ============================================================================
module avion_io_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int BASE_ADDR     = 60,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_data_in,
  output logic [DATA_WIDTH-1:0]    o_data_out,
  output logic                     o_sel,
  output logic [DATA_WIDTH-1:0]    o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_overflow
);

  // A single-entry FIFO still needs a 1-bit pointer to index the array.
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [ADDRESS_WIDTH-1:0] c_BASE     = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [c_PTR_W-1:0]       c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
  localparam logic [2:0]               c_DEPTH    = 3'(FIFO_DEPTH);

  localparam logic [1:0] c_OFF_TXDATA  = 2'd0;
  localparam logic [1:0] c_OFF_STATUS  = 2'd1;
  localparam logic [1:0] c_OFF_CYCLE   = 2'd2;
  localparam logic [1:0] c_OFF_SCRATCH = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [2:0]            count_q,  count_d;
  logic                  ovf_q,    ovf_d;
  logic [DATA_WIDTH-1:0] cycle_q,  cycle_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  sel_q,    sel_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic                  w_hit;
  logic [1:0]            w_off;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_ovf_clr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_hit   = (i_addr[ADDRESS_WIDTH-1:2] == c_BASE[ADDRESS_WIDTH-1:2]);
  assign w_off   = i_addr[1:0];
  assign w_empty = (count_q == 3'd0);
  assign w_full  = (count_q == c_DEPTH);

  // Head is forced to zero when empty so stale array contents never leak
  // onto o_tx_data or a TXDATA read.
  assign w_head  = w_empty ? '0 : mem_q[rd_ptr_q];

  assign w_push    = i_we && w_hit && (w_off == c_OFF_TXDATA);
  assign w_pop     = !w_empty && i_tx_ready;
  // A push into a full FIFO is only accepted when a pop frees the slot
  // on the same edge.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_clr = i_we && w_hit && (w_off == c_OFF_STATUS) && i_data_in[2];

  function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  always_comb begin
    w_status      = '0;
    w_status[5:0] = {count_q, ovf_q, w_full, w_empty};
  end

  // Read mux uses pre-edge state, giving read-before-write behaviour.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      c_OFF_TXDATA:  w_rdata = w_head;
      c_OFF_STATUS:  w_rdata = w_status;
      c_OFF_CYCLE:   w_rdata = cycle_q;
      c_OFF_SCRATCH: w_rdata = scratch_q;
      default:       w_rdata = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    cycle_d    = cycle_q + DATA_WIDTH'(1);
    scratch_d  = scratch_q;
    data_out_d = w_hit ? w_rdata : '0;
    sel_d      = w_hit;

    if (w_pop) begin
      rd_ptr_d = f_ptr_inc(rd_ptr_q);
    end
    if (w_push_ok) begin
      wr_ptr_d = f_ptr_inc(wr_ptr_q);
    end else if (w_push) begin
      ovf_d = 1'b1;
    end

    if (w_push_ok && !w_pop) begin
      count_d = count_q + 3'd1;
    end else if (!w_push_ok && w_pop) begin
      count_d = count_q - 3'd1;
    end

    if (w_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (i_we && w_hit && (w_off == c_OFF_CYCLE)) begin
      cycle_d = i_data_in;
    end
    if (i_we && w_hit && (w_off == c_OFF_SCRATCH)) begin
      scratch_d = i_data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cycle_q    <= '0;
      scratch_q  <= '0;
      data_out_q <= '0;
      sel_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cycle_q    <= cycle_d;
      scratch_q  <= scratch_d;
      data_out_q <= data_out_d;
      sel_q      <= sel_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      mem_q[wr_ptr_q] <= i_data_in;
    end
  end

  assign o_data_out = data_out_q;
  assign o_sel      = sel_q;
  assign o_tx_data  = w_head;
  assign o_tx_valid = !w_empty;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_avion_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_avion_io_responder
// Purpose  : Self-checking bench for avion_io_responder. A queue-based
//            behavioural model tracks the register file and FIFO; a compare
//            process checks every DUT output against it each cycle, and
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avion_io_responder;

  localparam int AW    = 6;
  localparam int DW    = 10;
  localparam int BASE  = 60;
  localparam int DEPTH = 4;
  localparam int unsigned c_MASK = (1 << DW) - 1;

  logic          clk;
  logic          rst;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data_in;
  logic [DW-1:0] o_data_out;
  logic          o_sel;
  logic [DW-1:0] o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready;
  logic          o_overflow;

  avion_io_responder #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_data_in (i_data_in),
    .o_data_out(o_data_out),
    .o_sel     (o_sel),
    .o_tx_data (o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .o_overflow(o_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int unsigned mq[$];
  int unsigned m_cyc, m_scr, m_ovf;
  int unsigned exp_dout, exp_sel;
  bit          model_ok = 0;

  always @(posedge clk) begin
    int unsigned a, d, off, rv, n;
    bit hit, pop;
    if (rst) begin
      mq.delete();
      m_cyc = 0; m_scr = 0; m_ovf = 0;
      exp_dout = 0; exp_sel = 0;
      model_ok = 1;
    end else begin
      a   = i_addr;
      d   = i_data_in;
      hit = ((a / 4) == (BASE / 4));
      off = a % 4;
      n   = mq.size();
      case (off)
        0:       rv = (n > 0) ? mq[0] : 0;
        1:       rv = (n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + 4 * m_ovf + 8 * n;
        2:       rv = m_cyc;
        default: rv = m_scr;
      endcase
      exp_sel  = hit ? 1 : 0;
      exp_dout = hit ? rv : 0;
      pop = (n > 0) && i_tx_ready;
      if (pop) void'(mq.pop_front());
      if (i_we && hit && off == 0) begin
        if (n == DEPTH && !pop) m_ovf = 1;
        else mq.push_back(d);
      end
      if (i_we && hit && off == 1 && ((d >> 2) & 1)) m_ovf = 0;
      if (i_we && hit && off == 2) m_cyc = d;
      else m_cyc = (m_cyc + 1) & c_MASK;
      if (i_we && hit && off == 3) m_scr = d;
    end
  end

  // Compare process: all outputs, every cycle once the model is initialised.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("data_out", o_data_out, exp_dout);
      chk("sel", o_sel, exp_sel);
      chk("tx_valid", o_tx_valid, (mq.size() > 0) ? 1 : 0);
      chk("tx_data", o_tx_data, (mq.size() > 0) ? mq[0] : 0);
      chk("overflow", o_overflow, m_ovf);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // --------------------------------------------------------------------------
  task automatic step(input bit we, input int unsigned addr, input int unsigned data);
    i_we      = we;
    i_addr    = AW'(addr);
    i_data_in = DW'(data);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int unsigned addr, input string name, input int unsigned exp,
                    input int unsigned exp_s);
    step(1'b0, addr, 0);
    chk(name, o_data_out, exp);
    chk({name, "_sel"}, o_sel, exp_s);
  endtask

  initial begin
    rst = 1'b1; i_we = 1'b0; i_addr = '0; i_data_in = '0; i_tx_ready = 1'b0;

    // Reset held for 10 cycles, outputs all zero.
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0);
    chk("rst_dout", o_data_out, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_txdata", o_tx_data, 0);
    chk("rst_ovf", o_overflow, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0);
    rd(62, "cycle_after_rst", 4, 1);

    // FIFO fill and overflow.
    for (int v = 1; v <= 5; v++) step(1'b1, 60, v);
    rd(61, "status_full_ovf", 38, 1);
    chk("ovf_flag", o_overflow, 1);
    i_tx_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk("drain_valid", o_tx_valid, 1);
      chk("drain_data", o_tx_data, v);
      step(1'b0, 0, 0);
    end
    chk("drained_valid", o_tx_valid, 0);
    step(1'b1, 61, 4);
    rd(61, "status_cleared", 1, 1);

    // Simultaneous push/pop at full.
    i_tx_ready = 1'b0;
    for (int v = 10; v <= 13; v++) step(1'b1, 60, v);
    i_tx_ready = 1'b1;
    chk("pp_head", o_tx_data, 10);
    step(1'b1, 60, 14);
    for (int v = 11; v <= 14; v++) begin
      chk("pp_data", o_tx_data, v);
      chk("pp_ovf", o_overflow, 0);
      step(1'b0, 0, 0);
    end
    chk("pp_empty", o_tx_valid, 0);

    // CYCLE load and wrap.
    step(1'b1, 62, 1022);
    rd(62, "cyc_k1", 1022, 1);
    rd(62, "cyc_k2", 1023, 1);
    rd(62, "cyc_k3", 0, 1);

    // Window decode.
    step(1'b1, 63, 'h2AA);
    step(1'b1, 59, 'h155);
    rd(63, "scratch", 'h2AA, 1);
    rd(59, "outside", 0, 0);

    // Reset mid-operation.
    i_tx_ready = 1'b0;
    for (int v = 0; v < 3; v++) step(1'b1, 60, 100 + v);
    i_tx_ready = 1'b1;
    rst = 1'b1;
    step(1'b0, 0, 0);
    rst = 1'b0;
    chk("midrst_valid", o_tx_valid, 0);
    rd(61, "midrst_status", 1, 1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned a, d;
      a = ($urandom_range(0, 9) < 7) ? (60 + $urandom_range(0, 3)) : $urandom_range(0, 63);
      d = $urandom_range(0, c_MASK);
      i_tx_ready = ($urandom_range(0, 2) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 1) == 1, a, d);
    end
    rst = 1'b0;
    step(1'b0, 0, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
